// File: rtl/aoi_seq_ctrl_if.sv
// Stimulus/response bus between the AOI self-test sequencer and the AOI gate block.
// The sequencer is the master (drives ina..ind, samples oute/outf/outg).
interface aoi_seq_ctrl_if;
    logic ina;
    logic inb;
    logic inc;
    logic ind;
    logic oute;
    logic outf;
    logic outg;

    modport master (
        output ina, inb, inc, ind,
        input  oute, outf, outg
    );

    modport slave (
        input  ina, inb, inc, ind,
        output oute, outf, outg
    );
endinterface

// File: rtl/aoi_seq_ctrl.sv
// Clocked exhaustive self-test sweep for the 4-input AOI block: holds each vector DWELL cycles,
// compares the three outputs, reports pass/err_cnt/fail_vec. Define AOI_SEQ_GRAY_EN for Gray order.
module aoi_seq_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    aoi_seq_ctrl_if.master        aoi,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [4:0]            err_cnt,
    output logic [3:0]            fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_step;
    logic [3:0] r_vec;
    logic [7:0] r_dwell;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err_cnt;
    logic [3:0] r_fail_vec;
    logic       r_first_seen;

    logic       w_exp_e;
    logic       w_exp_f;
    logic       w_exp_g;
    logic       w_mismatch;
    logic [3:0] w_step_nxt;
    logic [4:0] w_err_nxt;

    function automatic logic [3:0] vec_of(input logic [3:0] step);
`ifdef AOI_SEQ_GRAY_EN
        return step ^ (step >> 1);
`else
        return step;
`endif
    endfunction

    // Expected response derives from the applied vector, never from the sampled AOI outputs.
    always_comb begin
        w_exp_e    = r_vec[3] & r_vec[2];
        w_exp_f    = r_vec[1] & r_vec[0];
        w_exp_g    = ~(w_exp_e | w_exp_f);
        w_mismatch = (aoi.oute != w_exp_e) | (aoi.outf != w_exp_f) | (aoi.outg != w_exp_g);
        w_step_nxt = r_step + 4'd1;
        w_err_nxt  = r_err_cnt + {4'd0, w_mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_vec        <= '0;
            r_dwell      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_first_seen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vec  <= '0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_state      <= S_DRIVE;
                        r_step       <= '0;
                        r_vec        <= vec_of(4'd0);
                        r_dwell      <= '0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
                        r_fail_vec   <= '0;
                        r_first_seen <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_vec   <= '0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_dwell == 8'(DWELL - 1)) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_dwell <= r_dwell + 8'd1;
                    end
                end

                S_SAMPLE: begin
                    // Abort wins over the compare, so a partial sweep keeps only completed steps.
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_vec   <= '0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            r_err_cnt <= w_err_nxt;
                            if (!r_first_seen) begin
                                r_fail_vec   <= r_vec;
                                r_first_seen <= 1'b1;
                            end
                        end
                        if (r_step == 4'hF) begin
                            r_state <= S_DONE;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end else begin
                            r_state <= S_DRIVE;
                            r_step  <= w_step_nxt;
                            r_vec   <= vec_of(w_step_nxt);
                            r_dwell <= '0;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_vec   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign aoi.ina  = r_vec[3];
    assign aoi.inb  = r_vec[2];
    assign aoi.inc  = r_vec[1];
    assign aoi.ind  = r_vec[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_aoi_seq_ctrl.sv
// Directed bench for aoi_seq_ctrl: behavioural AOI with injectable stuck faults, DWELL=4 and DWELL=1 instances.
module tb_aoi_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_start = 1'b0;
    logic r_abort = 1'b0;
    logic sel1 = 1'b0;
    int   fault_mode = 0;     // 0 good, 1 outg stuck-0, 2 outf stuck-1
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    aoi_seq_ctrl_if u_if4 ();
    aoi_seq_ctrl_if u_if1 ();

    logic       busy4, done4, pass4, busy1, done1, pass1;
    logic [4:0] err4, err1;
    logic [3:0] fv4, fv1;
    logic       w_start4, w_abort4, w_start1, w_abort1;

    assign w_start4 = r_start & ~sel1;
    assign w_abort4 = r_abort & ~sel1;
    assign w_start1 = r_start & sel1;
    assign w_abort1 = r_abort & sel1;

    assign u_if4.oute = u_if4.ina & u_if4.inb;
    assign u_if4.outf = (fault_mode == 2) ? 1'b1 : (u_if4.inc & u_if4.ind);
    assign u_if4.outg = (fault_mode == 1) ? 1'b0 : ~((u_if4.ina & u_if4.inb) | (u_if4.inc & u_if4.ind));
    assign u_if1.oute = u_if1.ina & u_if1.inb;
    assign u_if1.outf = (fault_mode == 2) ? 1'b1 : (u_if1.inc & u_if1.ind);
    assign u_if1.outg = (fault_mode == 1) ? 1'b0 : ~((u_if1.ina & u_if1.inb) | (u_if1.inc & u_if1.ind));

    aoi_seq_ctrl #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(w_start4), .abort(w_abort4), .aoi(u_if4.master),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .fail_vec(fv4)
    );

    aoi_seq_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(w_start1), .abort(w_abort1), .aoi(u_if1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    logic       w_busy, w_done, w_pass;
    logic [4:0] w_err;
    logic [3:0] w_fv, w_vec;
    assign w_busy = sel1 ? busy1 : busy4;
    assign w_done = sel1 ? done1 : done4;
    assign w_pass = sel1 ? pass1 : pass4;
    assign w_err  = sel1 ? err1  : err4;
    assign w_fv   = sel1 ? fv1   : fv4;
    assign w_vec  = sel1 ? {u_if1.ina, u_if1.inb, u_if1.inc, u_if1.ind}
                         : {u_if4.ina, u_if4.inb, u_if4.inc, u_if4.ind};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_vec(input int step);
        logic [3:0] s;
        s = step[3:0];
`ifdef AOI_SEQ_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    // Runs one sweep from the current negedge. Cycle c=1 is the first cycle after the start edge.
    // stop_kind: 0 none, 1 abort asserted in cycle stop_cyc, 2 reset asserted in cycle stop_cyc.
    task automatic sweep(input int exp_err, input int exp_fv, input int exp_pass,
                         input bit hold_start, input int stop_kind, input int stop_cyc,
                         input int mid_cyc, input int mid_err);
        int         p;
        int         last;
        logic [3:0] prev;
        p    = sel1 ? 2 : 5;
        last = 16 * p + 1;
        prev = '0;
        r_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) r_start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c == 1) begin
                check("clr_err", w_err, 0);
                check("clr_fv", w_fv, 0);
                check("clr_pass", w_pass, 0);
            end
            if (stop_kind != 0 && c == stop_cyc + 1) begin
                r_abort = 1'b0;
                rst     = 1'b0;
                r_start = 1'b0;
                check("stop_busy", w_busy, 0);
                check("stop_done", w_done, 0);
                check("stop_vec", w_vec, 0);
                check("stop_pass", w_pass, 0);
                check("stop_err", w_err, exp_err);
                check("stop_fv", w_fv, exp_fv);
                @(negedge clk);
                check("stop_nodone", w_done, 0);
                check("stop_idle", w_busy, 0);
                break;
            end
            check("busy", w_busy, (c <= 16 * p) ? 1 : 0);
            check("done", w_done, (c == last) ? 1 : 0);
            check("vec", w_vec, (c <= 16 * p) ? exp_vec((c - 1) / p) : 4'd0);
`ifdef AOI_SEQ_GRAY_EN
            if (c > 1 && c <= 16 * p && w_vec != prev)
                check("gray1", $countones(w_vec ^ prev), 1);
`endif
            prev = w_vec;
            if (c == mid_cyc) check("mid_err", w_err, mid_err);
            if (c == last) begin
                check("pass", w_pass, exp_pass);
                check("err_cnt", w_err, exp_err);
                check("fail_vec", w_fv, exp_fv);
            end
            if (c == stop_cyc && stop_kind == 1) r_abort = 1'b1;
            if (c == stop_cyc && stop_kind == 2) rst = 1'b1;
            if (hold_start && c == 16 * p) r_start = 1'b0;
            @(negedge clk);
        end
        if (stop_kind == 0) begin
            check("done_once", w_done, 0);
            check("idle_busy", w_busy, 0);
            check("pass_hold", w_pass, exp_pass);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_pass", pass4, 0);
        check("rst_err", err4, 0);
        check("rst_fv", fv4, 0);
        check("rst_vec", {u_if4.ina, u_if4.inb, u_if4.inc, u_if4.ind}, 0);
        check("rst_busy1", busy1, 0);
        check("rst_vec1", {u_if1.ina, u_if1.inb, u_if1.inc, u_if1.ind}, 0);
        rst = 1'b0;
        @(negedge clk);

        sel1 = 1'b0;
        fault_mode = 0; sweep(0, 0, 1, 1'b0, 0, 0, 0, 0);
        fault_mode = 1; sweep(9, 0, 0, 1'b0, 0, 0, 0, 0);
        // steps 0..3 applied before cycle 21: three of them fail, vector 0011 (or its Gray slot) passes
        fault_mode = 2; sweep(12, 0, 0, 1'b0, 0, 0, 21, 3);
        fault_mode = 1; sweep(4, 0, 0, 1'b0, 1, 30, 0, 0);
        fault_mode = 0; sweep(0, 0, 1, 1'b0, 0, 0, 0, 0);
        fault_mode = 0; sweep(0, 0, 1, 1'b1, 0, 0, 0, 0);
        fault_mode = 1; sweep(0, 0, 0, 1'b1, 2, 30, 0, 0);

        sel1 = 1'b1;
        fault_mode = 0; sweep(0, 0, 1, 1'b0, 0, 0, 0, 0);
        fault_mode = 1; sweep(9, 0, 0, 1'b0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aoi_seq_ctrl.md
# aoi_seq_ctrl

Self-test sequencer for the 4-input AOI gate block (`ina`..`ind` in; `oute`, `outf`, `outg` out).
- Drives every 4-bit input vector into the AOI with a programmable hold time and samples its three outputs.
- Compares them against the expected AND-OR-INVERT function and reports a pass flag, mismatch count and first failing vector.
- Sits between board-level start/status logic and the combinational AOI instance, replacing free-running testbench stimulus with a clocked, repeatable sweep.

## Interface
- `DWELL`, default 4: cycles each vector is held before sampling; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level; sampled in IDLE only; begins a sweep.
- `abort` input 1: level; ends a sweep in progress without a done pulse.
- `oute` input 1: from AOI, expected `ina & inb`.
- `outf` input 1: from AOI, expected `inc & ind`.
- `outg` input 1: from AOI, expected `~(oute | outf)` (computed from applied inputs, not from sampled `oute`/`outf`).
- `ina`, `inb`, `inc`, `ind` output 1 each: registered drive to AOI; vector bit 3 → `ina`, bit 0 → `ind`.
- `busy` output 1: high in DRIVE and SAMPLE.
- `done` output 1: one-cycle pulse at normal sweep completion.
- `pass` output 1: high when the last completed sweep had zero mismatches.
- `err_cnt` output 5: vectors with at least one output mismatch, range 0..16.
- `fail_vec` output 4: applied vector value of the first mismatch in the last sweep.

## Operation
- States:
  - IDLE → DRIVE on `start`.
  - DRIVE: hold the vector for DWELL cycles, then → SAMPLE.
  - SAMPLE: compare; if step < 15, advance step and → DRIVE; if step = 15, → DONE.
  - DONE: → IDLE unconditionally.
- Step counter (4 bits) selects the vector. Binary order by default; see Configuration for Gray order.
- On IDLE→DRIVE:
  - Step = 0; `err_cnt`, `fail_vec` and `pass` clear to 0.
  - A first-fail flag clears.
- SAMPLE compares all three AOI outputs against values computed from the currently driven `ina`..`ind`.
  - Any mismatch: `err_cnt` += 1 (cannot exceed 16, so no saturation logic).
  - If this is the first mismatch of the sweep, `fail_vec` latches the applied vector and the first-fail flag sets.
- DONE: `done`=1 for exactly that cycle; `pass` = (`err_cnt`==0), held until the next start.
- `start` is ignored in DRIVE, SAMPLE and DONE. A `start` held high in the cycle after DONE begins a new sweep.
- `abort`:
  - In DRIVE or SAMPLE: → IDLE next cycle, with no done pulse and `pass`=0. `err_cnt`/`fail_vec` keep the partial values.
  - In SAMPLE: `abort` has priority over the compare, so no count update that cycle.
  - In IDLE/DONE: no effect.
- `ina`..`ind` are 0 in IDLE and DONE.
- Reset at any time:
  - Next state IDLE.
  - `ina`..`ind`, `busy`, `done`, `pass`, `err_cnt`, `fail_vec` all reset to 0.

## Timing
- `start` sampled high at edge N: DRIVE from N+1, with vector 0 on `ina`..`ind` in that same cycle (registered outputs).
- Each vector occupies DWELL DRIVE cycles plus 1 SAMPLE cycle. The vector stays applied through its SAMPLE cycle and changes on the edge leaving SAMPLE.
- Full sweep: 16×(DWELL+1) busy cycles. `done` is high at cycle N+1+16×(DWELL+1); with DWELL=4 that is N+81.
- `busy` covers exactly the DRIVE/SAMPLE cycles and is low in DONE.
- AOI outputs are assumed combinational and settled within DWELL cycles. Sampling happens in the SAMPLE cycle on the registered compare edge.
- `err_cnt`/`fail_vec` update on the edge ending SAMPLE.

## Configuration
- `AOI_SEQ_GRAY_EN` defined: vector = step ^ (step >> 1), a Gray sequence where exactly one of `ina`..`ind` toggles per step. This exposes single-input glitch/hazard behaviour.
- Not defined: vector = step (binary 0000..1111).
- Sweep length, timing and error semantics are identical in both modes. Only the vector order, and therefore `fail_vec` for multi-fault cases, differs.

## Test plan
- Correct AOI, DWELL=4, `start` at edge 0 → `busy` cycles 1..80, `done`=1 at cycle 81, `pass`=1, `err_cnt`=0, `fail_vec`=0.
- `outg` stuck at 0 → `err_cnt`=9 (vectors where both AND pairs are 0), `pass`=0, `fail_vec`=4'b0000; same count with `AOI_SEQ_GRAY_EN`.
- `outf` stuck at 1 → `err_cnt`=12, `fail_vec`=4'b0000. Binary mode: first vector with `outf` correct is 0011, and vector 0011 must not be counted.
- `abort` asserted during step 5 SAMPLE → IDLE next cycle, no `done`, `pass`=0, `ina`..`ind`=0; a new `start` restarts from vector 0 with cleared counters.
- `rst` pulsed mid-sweep (cycle 30) → all outputs 0 the following cycle; a `start` held high during `busy` has no effect.
- DWELL=1 with Gray mode → 32-cycle sweep, and each vector change flips exactly one of `ina`..`ind`.
